// File: rtl/gpc_mem_arbiter_if.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | gpc_mem_arbiter_if : IFU / LSU request-response channels plus memory port |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
interface gpc_mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
) ();
  localparam int MW = DW / 8;

  logic          ifu_req_valid;
  logic          ifu_req_ready;
  logic [AW-1:0] ifu_addr;
  logic          ifu_rsp_valid;
  logic [DW-1:0] ifu_rsp_data;

  logic          lsu_req_valid;
  logic          lsu_req_ready;
  logic [AW-1:0] lsu_addr;
  logic          lsu_wen;
  logic [DW-1:0] lsu_wdata;
  logic [MW-1:0] lsu_wmask;
  logic          lsu_rsp_valid;
  logic [DW-1:0] lsu_rsp_data;

  logic          mem_req_valid;
  logic          mem_req_ready;
  logic [AW-1:0] mem_addr;
  logic          mem_wen;
  logic [DW-1:0] mem_wdata;
  logic [MW-1:0] mem_wmask;
  logic          mem_rsp_valid;
  logic [DW-1:0] mem_rsp_data;

  // Arbiter view: target of both requesters, initiator toward memory.
  modport slave (
    input  ifu_req_valid, ifu_addr,
    output ifu_req_ready, ifu_rsp_valid, ifu_rsp_data,
    input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
    output lsu_req_ready, lsu_rsp_valid, lsu_rsp_data,
    output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data
  );

  // Environment view: requesters and memory model.
  modport master (
    output ifu_req_valid, ifu_addr,
    input  ifu_req_ready, ifu_rsp_valid, ifu_rsp_data,
    output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
    input  lsu_req_ready, lsu_rsp_valid, lsu_rsp_data,
    input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data
  );
endinterface
`default_nettype wire

// File: rtl/gpc_mem_arbiter.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | gpc_mem_arbiter : LSU-priority arbiter with IFU starvation guard, one     |
// | memory transaction outstanding at a time.   Rev 1.0                       |
// +---------------------------------------------------------------------------+
module gpc_mem_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_LIM = 4
) (
  input  logic              clk,
  input  logic              rst,
  gpc_mem_arbiter_if.slave  bus,
  output logic              busy
);
  localparam int MW = DW / 8;
  localparam int CW = $clog2(STARVE_LIM + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  localparam logic OWN_IFU = 1'b0;
  localparam logic OWN_LSU = 1'b1;

  logic [1:0]    state_q, state_d;
  logic          owner_q, owner_d;
  logic [CW-1:0] starve_cnt_q, starve_cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          wen_q, wen_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [MW-1:0] wmask_q, wmask_d;

  logic is_idle;
  logic ifu_starved;
  logic grant_lsu;
  logic grant_ifu;
  logic rsp_fire;

  assign is_idle     = (state_q == ST_IDLE);
  assign ifu_starved = bus.ifu_req_valid && (starve_cnt_q == CW'(STARVE_LIM));
  assign grant_lsu   = is_idle && bus.lsu_req_valid && !ifu_starved;
  assign grant_ifu   = is_idle && bus.ifu_req_valid && !grant_lsu;
  assign rsp_fire    = (state_q == ST_WAIT) && bus.mem_rsp_valid;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    starve_cnt_d = starve_cnt_q;
    addr_d       = addr_q;
    wen_d        = wen_q;
    wdata_d      = wdata_q;
    wmask_d      = wmask_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_lsu) begin
          state_d = ST_REQ;
          owner_d = OWN_LSU;
          addr_d  = bus.lsu_addr;
          wen_d   = bus.lsu_wen;
          wdata_d = bus.lsu_wdata;
          wmask_d = bus.lsu_wmask;
          // Count only grants that actually made a waiting fetch wait longer.
          if (!bus.ifu_req_valid)
            starve_cnt_d = '0;
          else if (starve_cnt_q != CW'(STARVE_LIM))
            starve_cnt_d = starve_cnt_q + 1'b1;
        end else if (grant_ifu) begin
          state_d      = ST_REQ;
          owner_d      = OWN_IFU;
          addr_d       = bus.ifu_addr;
          wen_d        = 1'b0;
          wdata_d      = '0;
          wmask_d      = '0;
          starve_cnt_d = '0;
        end
      end
      ST_REQ:  if (bus.mem_req_ready) state_d = ST_WAIT;
      ST_WAIT: if (bus.mem_rsp_valid) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWN_IFU;
      starve_cnt_q <= '0;
      addr_q       <= '0;
      wen_q        <= 1'b0;
      wdata_q      <= '0;
      wmask_q      <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      starve_cnt_q <= starve_cnt_d;
      addr_q       <= addr_d;
      wen_q        <= wen_d;
      wdata_q      <= wdata_d;
      wmask_q      <= wmask_d;
    end
  end

  // Grants are combinational from the valids, so mask them while reset is held.
  assign bus.ifu_req_ready = grant_ifu && rst;
  assign bus.lsu_req_ready = grant_lsu && rst;

  assign bus.ifu_rsp_valid = rsp_fire && (owner_q == OWN_IFU);
  assign bus.lsu_rsp_valid = rsp_fire && (owner_q == OWN_LSU);
  assign bus.ifu_rsp_data  = bus.ifu_rsp_valid ? bus.mem_rsp_data : '0;
  assign bus.lsu_rsp_data  = bus.lsu_rsp_valid ? bus.mem_rsp_data : '0;

  assign bus.mem_req_valid = (state_q == ST_REQ);
  assign bus.mem_addr      = addr_q;
  assign bus.mem_wen       = wen_q;
  assign bus.mem_wdata     = wdata_q;
  assign bus.mem_wmask     = wmask_q;

  assign busy = !is_idle;
endmodule
`default_nettype wire

// File: tb/tb_gpc_mem_arbiter.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_gpc_mem_arbiter : directed self-checking bench for gpc_mem_arbiter     |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_gpc_mem_arbiter;
  logic clk;
  logic rst;
  logic busy;
  int   checks;
  int   failures;

  gpc_mem_arbiter_if #(.AW(32), .DW(32)) bus ();

  gpc_mem_arbiter #(.AW(32), .DW(32), .STARVE_LIM(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus.slave),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    bus.ifu_req_valid = 1'b0;
    bus.ifu_addr      = '0;
    bus.lsu_req_valid = 1'b0;
    bus.lsu_addr      = '0;
    bus.lsu_wen       = 1'b0;
    bus.lsu_wdata     = '0;
    bus.lsu_wmask     = '0;
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data  = '0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    bus.ifu_req_valid = 1'b1;
    bus.ifu_addr      = 32'h8000_0000;
    bus.lsu_req_valid = 1'b1;
    bus.lsu_addr      = 32'h1234_5678;
    bus.mem_req_ready = 1'b1;
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = 32'hFFFF_FFFF;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.ifu_req_ready, bus.lsu_req_ready, bus.ifu_rsp_valid, bus.lsu_rsp_valid,
         bus.mem_req_valid, bus.mem_wen, busy} !== 7'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got %b expected 0000000",
               {bus.ifu_req_ready, bus.lsu_req_ready, bus.ifu_rsp_valid, bus.lsu_rsp_valid,
                bus.mem_req_valid, bus.mem_wen, busy});
    end
    checks++;
    if ({bus.mem_addr, bus.mem_wdata, bus.mem_wmask, bus.ifu_rsp_data, bus.lsu_rsp_data} !== '0) begin
      failures++;
      $display("FAIL reset_data: addr=%h wdata=%h wmask=%h ifu_rsp=%h lsu_rsp=%h expected all 0",
               bus.mem_addr, bus.mem_wdata, bus.mem_wmask, bus.ifu_rsp_data, bus.lsu_rsp_data);
    end
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.lsu_req_ready, bus.ifu_req_ready} !== 2'b10) begin
      failures++;
      $display("FAIL reset_first_grant: lsu_ready,ifu_ready=%b expected 10",
               {bus.lsu_req_ready, bus.ifu_req_ready});
    end
    do_reset();
  endtask

  task automatic test_ifu_only();
    bus.ifu_req_valid = 1'b1;
    bus.ifu_addr      = 32'h8000_0000;
    bus.mem_req_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.ifu_req_ready, bus.lsu_req_ready} !== 2'b10) begin
      failures++;
      $display("FAIL ifu_grant: ifu_ready,lsu_ready=%b expected 10",
               {bus.ifu_req_ready, bus.lsu_req_ready});
    end
    @(posedge clk); #1 bus.ifu_req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.mem_req_valid !== 1'b1 || bus.mem_addr !== 32'h8000_0000 ||
        bus.mem_wen !== 1'b0 || bus.mem_wmask !== 4'h0) begin
      failures++;
      $display("FAIL ifu_mem_req: valid=%b addr=%h wen=%b wmask=%h expected 1 80000000 0 0",
               bus.mem_req_valid, bus.mem_addr, bus.mem_wen, bus.mem_wmask);
    end
    @(posedge clk); #1;
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = 32'h0010_0073;
    @(negedge clk);
    checks++;
    if (bus.ifu_rsp_valid !== 1'b1 || bus.ifu_rsp_data !== 32'h0010_0073 || bus.lsu_rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL ifu_rsp: ifu_valid=%b data=%h lsu_valid=%b expected 1 00100073 0",
               bus.ifu_rsp_valid, bus.ifu_rsp_data, bus.lsu_rsp_valid);
    end
    @(posedge clk); #1 bus.mem_rsp_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.ifu_rsp_valid !== 1'b0 || bus.ifu_rsp_data !== 32'h0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL ifu_after_rsp: ifu_valid=%b data=%h busy=%b expected 0 0 0",
               bus.ifu_rsp_valid, bus.ifu_rsp_data, busy);
    end
    do_reset();
  endtask

  task automatic test_contention();
    bit exp_lsu [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    bit got_lsu;
    bit seen;
    bus.ifu_req_valid = 1'b1;
    bus.ifu_addr      = 32'h8000_0040;
    bus.lsu_req_valid = 1'b1;
    bus.lsu_addr      = 32'h0000_2000;
    bus.mem_req_ready = 1'b1;
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = 32'hA5A5_0000;
    for (int g = 0; g < 10; g++) begin
      seen = 1'b0;
      got_lsu = 1'b0;
      for (int t = 0; t < 6 && !seen; t++) begin
        @(negedge clk);
        if (bus.ifu_req_ready || bus.lsu_req_ready) begin
          seen = 1'b1;
          got_lsu = bus.lsu_req_ready;
          checks++;
          if (bus.ifu_req_ready && bus.lsu_req_ready) begin
            failures++;
            $display("FAIL contend_one_ready: grant %0d both ready high, expected one", g);
          end
        end
      end
      checks++;
      if (!seen) begin
        failures++;
        $display("FAIL contend_timeout: grant %0d no ready within 6 cycles, expected one", g);
      end else if (got_lsu !== exp_lsu[g]) begin
        failures++;
        $display("FAIL contend_order: grant %0d lsu=%b expected lsu=%b", g, got_lsu, exp_lsu[g]);
      end
      if (seen) begin
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.lsu_rsp_valid, bus.ifu_rsp_valid} !== {exp_lsu[g], !exp_lsu[g]}) begin
          failures++;
          $display("FAIL contend_rsp_owner: grant %0d lsu_rsp,ifu_rsp=%b expected %b", g,
                   {bus.lsu_rsp_valid, bus.ifu_rsp_valid}, {exp_lsu[g], !exp_lsu[g]});
        end
      end
    end
    do_reset();
  endtask

  task automatic test_store();
    bus.lsu_req_valid = 1'b1;
    bus.lsu_addr      = 32'h8000_0100;
    bus.lsu_wen       = 1'b1;
    bus.lsu_wdata     = 32'hDEAD_BEEF;
    bus.lsu_wmask     = 4'b0011;
    bus.mem_req_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.lsu_req_ready !== 1'b1) begin
      failures++;
      $display("FAIL store_grant: lsu_ready=%b expected 1", bus.lsu_req_ready);
    end
    @(posedge clk); #1;
    bus.lsu_req_valid = 1'b0;
    bus.lsu_addr      = 32'h0BAD_0BAD;
    bus.lsu_wen       = 1'b0;
    bus.lsu_wdata     = 32'h1111_2222;
    bus.lsu_wmask     = 4'b1100;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) bus.mem_req_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.mem_req_valid !== 1'b1 || bus.mem_addr !== 32'h8000_0100 || bus.mem_wen !== 1'b1 ||
          bus.mem_wdata !== 32'hDEAD_BEEF || bus.mem_wmask !== 4'b0011) begin
        failures++;
        $display("FAIL store_req_c%0d: valid=%b addr=%h wen=%b wdata=%h wmask=%b expected 1 80000100 1 deadbeef 0011",
                 c, bus.mem_req_valid, bus.mem_addr, bus.mem_wen, bus.mem_wdata, bus.mem_wmask);
      end
      @(posedge clk); #1;
    end
    bus.mem_req_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.mem_req_valid !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL store_wait: mem_req_valid=%b busy=%b expected 0 1", bus.mem_req_valid, busy);
    end
    @(posedge clk); #1;
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = 32'h0000_0000;
    @(negedge clk);
    checks++;
    if ({bus.lsu_rsp_valid, bus.ifu_rsp_valid} !== 2'b10) begin
      failures++;
      $display("FAIL store_rsp: lsu_rsp,ifu_rsp=%b expected 10", {bus.lsu_rsp_valid, bus.ifu_rsp_valid});
    end
    do_reset();
  endtask

  task automatic test_stray_rsp();
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = 32'hCAFE_F00D;
    @(negedge clk);
    checks++;
    if ({bus.ifu_rsp_valid, bus.lsu_rsp_valid, busy} !== 3'b000) begin
      failures++;
      $display("FAIL stray_idle: ifu_rsp,lsu_rsp,busy=%b expected 000",
               {bus.ifu_rsp_valid, bus.lsu_rsp_valid, busy});
    end
    @(posedge clk); #1;
    bus.ifu_req_valid = 1'b1;
    bus.ifu_addr      = 32'h8000_0004;
    @(negedge clk);
    checks++;
    if ({bus.ifu_req_ready, bus.ifu_rsp_valid, bus.lsu_rsp_valid} !== 3'b100) begin
      failures++;
      $display("FAIL stray_grant: ifu_ready,ifu_rsp,lsu_rsp=%b expected 100",
               {bus.ifu_req_ready, bus.ifu_rsp_valid, bus.lsu_rsp_valid});
    end
    @(posedge clk); #1 bus.ifu_req_valid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if ({bus.mem_req_valid, bus.ifu_rsp_valid, bus.lsu_rsp_valid, bus.ifu_rsp_data} !== {3'b100, 32'h0}) begin
        failures++;
        $display("FAIL stray_req: mem_req_valid=%b ifu_rsp=%b lsu_rsp=%b ifu_data=%h expected 1 0 0 0",
                 bus.mem_req_valid, bus.ifu_rsp_valid, bus.lsu_rsp_valid, bus.ifu_rsp_data);
      end
    end
    do_reset();
  endtask

  task automatic test_reset_in_wait();
    bus.lsu_req_valid = 1'b1;
    bus.lsu_addr      = 32'h0000_3000;
    bus.mem_req_ready = 1'b1;
    @(posedge clk); #1 bus.lsu_req_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || bus.mem_req_valid !== 1'b0) begin
      failures++;
      $display("FAIL rwait_setup: busy=%b mem_req_valid=%b expected 1 0", busy, bus.mem_req_valid);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || bus.mem_addr !== 32'h0) begin
      failures++;
      $display("FAIL rwait_async: busy=%b mem_addr=%h expected 0 0", busy, bus.mem_addr);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = 32'h7777_7777;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if ({bus.lsu_rsp_valid, bus.ifu_rsp_valid, busy, bus.lsu_rsp_data} !== {3'b000, 32'h0}) begin
        failures++;
        $display("FAIL rwait_late_rsp: lsu_rsp=%b ifu_rsp=%b busy=%b lsu_data=%h expected 0 0 0 0",
                 bus.lsu_rsp_valid, bus.ifu_rsp_valid, busy, bus.lsu_rsp_data);
      end
    end
    do_reset();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    idle_inputs();
    test_reset();
    test_ifu_only();
    test_contention();
    test_store();
    test_stray_rsp();
    test_reset_in_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire
